// File: rtl/axi4_dpram_ctrl_pkg.sv
// Shared encodings and types for the AXI4 dpram64 front end.
package axi4_dpram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int RD_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } rd_state_t;

endpackage

// File: rtl/axi4_dpram_ctrl_if.sv
// AXI4 bus bundle between the SoC interconnect (master) and the dpram controller (slave).
interface axi4_dpram_ctrl_if #(
  parameter int AW   = 16,
  parameter int ID_W = 4
);
  logic [ID_W-1:0] awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [ID_W-1:0] arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_dpram_ctrl_rd_ret_fifo.sv
// Read return buffer: DEPTH x W synchronous FIFO, head visible combinationally.
// Latency: push to non-empty 1 cycle; push while full and pop while empty are ignored.
module rd_ret_fifo
  import axi4_dpram_pkg::*;
#(
  parameter  int DEPTH = RD_FIFO_DEPTH,
  parameter  int W     = 65,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi4_dpram_ctrl.sv
// AXI4 slave front end for dpram64: bursts to byte-enabled RAM writes / registered reads.
// Latency: write beat to RAM same cycle, AR to RVALID 3 cycles; RREADY backpressure absorbed by a 4-entry return FIFO.
module axi4_dpram_ctrl
  import axi4_dpram_pkg::*;
#(
  parameter  int SIZE = 65536,
  parameter  int ID_W = 4,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  axi4_dpram_ctrl_if.slave axi,
  output logic [7:0]       ram_we,
  output logic [63:0]      ram_din,
  output logic [AW-1:0]    ram_waddr,
  output logic [AW-1:0]    ram_raddr,
  input  logic [63:0]      ram_dout
);

  localparam int FCW = $clog2(RD_FIFO_DEPTH) + 1;

  // Holds both address readies low until the first clock after reset release.
  logic rdy_en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en_q <= 1'b0;
    else     rdy_en_q <= 1'b1;
  end

  // ---------------- write engine ----------------
  wr_state_t       wr_state_q, wr_state_d;
  logic [AW-1:0]   wr_addr_q;
  logic [1:0]      wr_burst_q;
  logic [ID_W-1:0] bid_q;
  logic            aw_hs, w_hs, b_hs;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;
  assign b_hs  = axi.bvalid && axi.bready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_state_q <= W_IDLE;
    else     wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_IDLE:  if (aw_hs) wr_state_d = W_DATA;
      W_DATA:  if (w_hs && axi.wlast) wr_state_d = W_RESP;
      W_RESP:  if (b_hs) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    axi.awready = rdy_en_q && (wr_state_q == W_IDLE);
    axi.wready  = (wr_state_q == W_DATA);
    axi.bvalid  = (wr_state_q == W_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q  <= '0;
      wr_burst_q <= BURST_FIXED;
      bid_q      <= '0;
    end else if (aw_hs) begin
      wr_addr_q  <= {axi.awaddr[AW-1:3], 3'b000};
      wr_burst_q <= axi.awburst;
      bid_q      <= axi.awid;
    end else if (w_hs && (wr_burst_q != BURST_FIXED)) begin
      wr_addr_q  <= wr_addr_q + AW'(8);
    end
  end

  assign ram_we    = w_hs ? axi.wstrb : 8'h00;
  assign ram_din   = w_hs ? axi.wdata : 64'h0;
  assign ram_waddr = wr_addr_q;
  assign axi.bid   = bid_q;
  assign axi.bresp = RESP_OKAY;

  // ---------------- read engine ----------------
  rd_state_t       rd_state_q, rd_state_d;
  logic [AW-1:0]   rd_addr_q;
  logic [AW-1:0]   raddr_hold_q;
  logic [1:0]      rd_burst_q;
  logic [ID_W-1:0] rid_q;
  logic [8:0]      rd_left_q;
  logic            pend_q, pend_last_q;
  logic [FCW-1:0]  fifo_count;
  logic            fifo_full, fifo_empty;
  logic [64:0]     fifo_dout;
  logic            ar_hs, issue, pop;

  assign ar_hs = axi.arvalid && axi.arready;
  assign pop   = axi.rvalid && axi.rready;
  // A beat in flight through the RAM counts against FIFO space so it can always be pushed.
  assign issue = (rd_state_q == R_BURST) && (rd_left_q != 9'd0) && !fifo_full &&
                 ((fifo_count + FCW'(pend_q)) < FCW'(RD_FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_state_q <= R_IDLE;
    else     rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (ar_hs) rd_state_d = R_BURST;
      R_BURST: if (pop && fifo_dout[0]) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    axi.arready = rdy_en_q && (rd_state_q == R_IDLE);
    axi.rvalid  = !fifo_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q    <= '0;
      raddr_hold_q <= '0;
      rd_burst_q   <= BURST_FIXED;
      rid_q        <= '0;
      rd_left_q    <= '0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
    end else begin
      pend_q      <= issue;
      pend_last_q <= issue && (rd_left_q == 9'd1);
      if (ar_hs) begin
        rd_addr_q  <= {axi.araddr[AW-1:3], 3'b000};
        rd_burst_q <= axi.arburst;
        rid_q      <= axi.arid;
        rd_left_q  <= {1'b0, axi.arlen} + 9'd1;
      end else if (issue) begin
        raddr_hold_q <= rd_addr_q;
        rd_left_q    <= rd_left_q - 9'd1;
        if (rd_burst_q != BURST_FIXED) rd_addr_q <= rd_addr_q + AW'(8);
      end
    end
  end

  assign ram_raddr = issue ? rd_addr_q : raddr_hold_q;

  rd_ret_fifo #(
    .DEPTH (RD_FIFO_DEPTH),
    .W     (65)
  ) u_rd_ret_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pend_q),
    .din   ({ram_dout, pend_last_q}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign axi.rdata = fifo_dout[64:1];
  assign axi.rlast = fifo_dout[0];
  assign axi.rid   = rid_q;
  assign axi.rresp = RESP_OKAY;

  // Beat size and length on AW, plus sub-word address bits, have no effect on this RAM.
  logic unused_inputs;
  assign unused_inputs = ^{axi.awlen, axi.awsize, axi.arsize, axi.awaddr[2:0], axi.araddr[2:0]};

endmodule

// File: tb/tb_axi4_dpram_ctrl.sv
// Randomised AXI4 bursts against a behavioural dpram64 and a byte-level shadow memory.
module tb_axi4_dpram_ctrl;
  import axi4_dpram_pkg::*;

  localparam int SIZE = 65536;
  localparam int AW   = 16;
  localparam int ID_W = 4;
  localparam int NW   = SIZE / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_dpram_ctrl_if #(.AW(AW), .ID_W(ID_W)) ax ();

  logic [7:0]    ram_we;
  logic [63:0]   ram_din;
  logic [63:0]   ram_dout;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;

  axi4_dpram_ctrl #(.SIZE(SIZE), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (ax),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_waddr (ram_waddr),
    .ram_raddr (ram_raddr),
    .ram_dout  (ram_dout)
  );

  // dpram64 stand-in: byte-enabled write, registered read-before-write.
  logic [63:0] ram [NW] = '{default: '0};
  always @(posedge clk) begin
    for (int b = 0; b < 8; b++)
      if (ram_we[b]) ram[ram_waddr[AW-1:3]][b*8 +: 8] <= ram_din[b*8 +: 8];
    ram_dout <= ram[ram_raddr[AW-1:3]];
  end

  // Reference contents as seen from the AXI side.
  logic [63:0] ref_mem [NW] = '{default: '0};
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input int i,
                                             input logic [1:0] burst);
    logic [AW-1:0] base;
    base = a & ~AW'(7);
    if (burst == BURST_FIXED) return base;
    return base + AW'(8 * i);
  endfunction

  task automatic wr_burst(input logic [ID_W-1:0] id, input logic [AW-1:0] addr,
                          input int len, input logic [1:0] burst);
    int t;
    logic [AW-1:0] ba;
    @(negedge clk);
    ax.awid = id; ax.awaddr = addr; ax.awlen = 8'(len); ax.awsize = 3'd3;
    ax.awburst = burst; ax.awvalid = 1'b1;
    t = 0; #1;
    while (!ax.awready && t < 200) begin @(negedge clk); #1; t++; end
    n_cmp++;
    if (ax.awready !== 1'b1) begin
      n_fail++; $display("FAIL aw_accept: awready=%b required 1", ax.awready);
    end
    @(posedge clk); #1 ax.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      ax.wdata = wd[i]; ax.wstrb = ws[i]; ax.wlast = (i == len); ax.wvalid = 1'b1;
      t = 0; #1;
      while (!ax.wready && t < 200) begin @(negedge clk); #1; t++; end
      ba = beat_addr(addr, i, burst);
      n_cmp++;
      if (ax.wready !== 1'b1) begin
        n_fail++; $display("FAIL w_accept beat %0d: wready=%b required 1", i, ax.wready);
      end
      n_cmp++;
      if (ram_we !== ws[i]) begin
        n_fail++; $display("FAIL ram_we beat %0d: got %h required %h", i, ram_we, ws[i]);
      end
      n_cmp++;
      if (ram_din !== wd[i]) begin
        n_fail++; $display("FAIL ram_din beat %0d: got %h required %h", i, ram_din, wd[i]);
      end
      n_cmp++;
      if (ram_waddr !== ba) begin
        n_fail++; $display("FAIL ram_waddr beat %0d: got %h required %h", i, ram_waddr, ba);
      end
      @(posedge clk);
      for (int b = 0; b < 8; b++)
        if (ws[i][b]) ref_mem[ba[AW-1:3]][b*8 +: 8] = wd[i][b*8 +: 8];
      #1 ax.wvalid = 1'b0; ax.wlast = 1'b0;
    end
    @(negedge clk); #1;
    n_cmp++;
    if (ax.bvalid !== 1'b1 || ax.bid !== id || ax.bresp !== RESP_OKAY) begin
      n_fail++;
      $display("FAIL bresp: bvalid=%b bid=%h bresp=%b required 1/%h/00", ax.bvalid, ax.bid, ax.bresp, id);
    end
    n_cmp++;
    if (ram_we !== 8'h00) begin
      n_fail++; $display("FAIL ram_we_idle: got %h required 00", ram_we);
    end
    ax.bready = 1'b1;
    @(posedge clk); #1 ax.bready = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (ax.bvalid !== 1'b0 || ax.awready !== 1'b1) begin
      n_fail++;
      $display("FAIL b_done: bvalid=%b awready=%b required 0/1", ax.bvalid, ax.awready);
    end
  endtask

  // rmode: 0 rready high, 1 toggling, 2 random
  task automatic rd_burst(input logic [ID_W-1:0] id, input logic [AW-1:0] addr, input int len,
                          input logic [1:0] burst, input int rmode, input bit chk_lat);
    int t, beat, ncyc, first;
    bit ph;
    logic [AW-1:0] ba;
    logic [63:0] exp;
    @(negedge clk);
    ax.arid = id; ax.araddr = addr; ax.arlen = 8'(len); ax.arsize = 3'd3;
    ax.arburst = burst; ax.arvalid = 1'b1;
    t = 0; #1;
    while (!ax.arready && t < 200) begin @(negedge clk); #1; t++; end
    n_cmp++;
    if (ax.arready !== 1'b1) begin
      n_fail++; $display("FAIL ar_accept: arready=%b required 1", ax.arready);
    end
    @(posedge clk); #1 ax.arvalid = 1'b0;
    beat = 0; ncyc = 0; first = -1; ph = 1'b1;
    while (beat <= len && ncyc < 400) begin
      @(negedge clk);
      ncyc++;
      case (rmode)
        0:       ax.rready = 1'b1;
        1:       begin ax.rready = ph; ph = !ph; end
        default: ax.rready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (ax.rvalid && first < 0) first = ncyc;
      if (ax.rvalid && ax.rready) begin
        ba  = beat_addr(addr, beat, burst);
        exp = ref_mem[ba[AW-1:3]];
        n_cmp++;
        if (ax.rdata !== exp) begin
          n_fail++; $display("FAIL rdata beat %0d: got %h required %h", beat, ax.rdata, exp);
        end
        n_cmp++;
        if (ax.rlast !== (beat == len) || ax.rid !== id || ax.rresp !== RESP_OKAY) begin
          n_fail++;
          $display("FAIL rctl beat %0d: rlast=%b rid=%h rresp=%b required %b/%h/00",
                   beat, ax.rlast, ax.rid, ax.rresp, (beat == len), id);
        end
        beat++;
      end
    end
    @(negedge clk);
    ax.rready = 1'b0;
    #1;
    n_cmp++;
    if (beat != len + 1) begin
      n_fail++; $display("FAIL r_count: got %0d beats required %0d", beat, len + 1);
    end
    n_cmp++;
    if (ax.rvalid !== 1'b0 || ax.arready !== 1'b1) begin
      n_fail++;
      $display("FAIL r_done: rvalid=%b arready=%b required 0/1", ax.rvalid, ax.arready);
    end
    if (chk_lat) begin
      n_cmp++;
      if (first != 3) begin
        n_fail++; $display("FAIL r_latency: rvalid after %0d cycles required 3", first);
      end
    end
  endtask

  task automatic fill_rand(input logic [AW-1:0] addr, input int len);
    for (int i = 0; i <= len; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = 8'hFF;
    end
    wr_burst(4'(ID_W'($urandom)), addr, len, BURST_INCR);
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({ax.awready, ax.arready, ax.wready, ax.bvalid, ax.rvalid, ram_we} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_ctl: aw/ar/w/b/r=%b%b%b%b%b ram_we=%h required all 0",
               ax.awready, ax.arready, ax.wready, ax.bvalid, ax.rvalid, ram_we);
    end
    n_cmp++;
    if ({ram_waddr, ram_raddr, ram_din, ax.rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: waddr=%h raddr=%h din=%h rdata=%h required 0",
               ram_waddr, ram_raddr, ram_din, ax.rdata);
    end
    n_cmp++;
    if ({ax.bid, ax.rid, ax.bresp, ax.rresp, ax.rlast} !== '0) begin
      n_fail++;
      $display("FAIL reset_resp: bid=%h rid=%h bresp=%b rresp=%b rlast=%b required 0",
               ax.bid, ax.rid, ax.bresp, ax.rresp, ax.rlast);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ax.arready !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: arready=%b required 0", ax.arready);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (ax.awready !== 1'b1 || ax.arready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_rise: awready=%b arready=%b required 1/1", ax.awready, ax.arready);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      wd[i] = 64'(8'h11 * (i + 1));
      ws[i] = 8'hFF;
    end
    wr_burst(4'h3, 16'h0100, 3, BURST_INCR);
    rd_burst(4'h5, 16'h0100, 3, BURST_INCR, 0, 1'b1);
  endtask

  task automatic test_partial_strobe();
    wd[0] = 64'h0; ws[0] = 8'hFF;
    wr_burst(4'h1, 16'h0040, 0, BURST_INCR);
    wd[0] = 64'hAABBCCDD_EEFF0011; ws[0] = 8'h0F;
    wr_burst(4'h2, 16'h0040, 0, BURST_INCR);
    rd_burst(4'h7, 16'h0040, 0, BURST_INCR, 0, 1'b1);
  endtask

  task automatic test_rready_toggle();
    fill_rand(16'h0800, 15);
    rd_burst(4'hA, 16'h0800, 15, BURST_INCR, 1, 1'b1);
  endtask

  task automatic test_fixed_wrap();
    fill_rand(16'h0200, 3);
    rd_burst(4'h4, 16'h0200, 3, BURST_FIXED, 0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = 8'hFF;
    end
    wr_burst(4'h6, AW'(SIZE - 8), 1, BURST_WRAP);
    rd_burst(4'h9, AW'(SIZE - 8), 1, BURST_INCR, 0, 1'b0);
  endtask

  task automatic test_concurrent();
    fill_rand(16'h1000, 7);
    for (int i = 0; i < 8; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = 8'($urandom);
    end
    fork
      wr_burst(4'hC, 16'h2000, 7, BURST_INCR);
      rd_burst(4'hD, 16'h1000, 7, BURST_INCR, 0, 1'b1);
    join
    rd_burst(4'hE, 16'h2000, 7, BURST_INCR, 2, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    int t;
    fill_rand(16'h0300, 7);
    @(negedge clk);
    ax.arid = 4'h2; ax.araddr = 16'h0300; ax.arlen = 8'd7; ax.arsize = 3'd3;
    ax.arburst = BURST_INCR; ax.arvalid = 1'b1; ax.rready = 1'b0;
    t = 0; #1;
    while (!ax.arready && t < 200) begin @(negedge clk); #1; t++; end
    @(posedge clk); #1 ax.arvalid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_cmp++;
    if (ax.rvalid !== 1'b1) begin
      n_fail++; $display("FAIL mid_held: rvalid=%b required 1", ax.rvalid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ax.rvalid !== 1'b0 || ax.arready !== 1'b0 || ax.awready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: rvalid=%b arready=%b awready=%b required 0/0/0",
               ax.rvalid, ax.arready, ax.awready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (ax.arready !== 1'b1 || ax.rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_release: arready=%b rvalid=%b required 1/0", ax.arready, ax.rvalid);
    end
    rd_burst(4'h8, 16'h0300, 7, BURST_INCR, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int len;
    for (int k = 0; k < 12; k++) begin
      a   = AW'($urandom);
      len = $urandom_range(0, 7);
      for (int i = 0; i <= len; i++) begin
        wd[i] = {$urandom, $urandom};
        ws[i] = 8'($urandom);
      end
      wr_burst(ID_W'($urandom), a, len, 2'($urandom_range(0, 2)));
      rd_burst(ID_W'($urandom), a, $urandom_range(0, 7), 2'($urandom_range(0, 2)), 2, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ax.awid = '0; ax.awaddr = '0; ax.awlen = '0; ax.awsize = '0; ax.awburst = '0; ax.awvalid = 1'b0;
    ax.wdata = '0; ax.wstrb = '0; ax.wlast = 1'b0; ax.wvalid = 1'b0; ax.bready = 1'b0;
    ax.arid = '0; ax.araddr = '0; ax.arlen = '0; ax.arsize = '0; ax.arburst = '0; ax.arvalid = 1'b0;
    ax.rready = 1'b0;
    test_reset();
    test_basic();
    test_partial_strobe();
    test_rready_toggle();
    test_fixed_wrap();
    test_concurrent();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
